md_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline, placed beside the EX-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from EX, latches operands, and counts a fixed latency per operation.
- Writes HI/LO when the operation completes.
- Exports busy_real to the hazard/stall logic, so any HI/LO-dependent instruction in ID stalls while an operation is running or being launched.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_sequencer_if.sv | 25 ++
 rtl/md_arith.sv | 76 +++++++
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e    : EX-stage MD operation encodings (7 is reserved, treated as none)
//   md_state_e : sequencer FSM states
//   *_DEF      : default per-operation busy latencies
//   is_muldiv  : true for the ops that occupy the sequencer (mult/multu/div/divu)
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  // Latencies are limited to 1..15, so a 4-bit down-counter suffices.
  localparam int CNT_W           = 4;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> MD sequencer bus.
//   start/md_op/rs_val/rt_val : request from EX (master drives)
//   busy/busy_real/done       : status to hazard logic
//   hi/lo                     : architectural HI/LO registers
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        busy_real;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, busy_real, done, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, busy_real, done, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath for the MD sequencer.
//   op_i     : latched MD op
//   rs_i     : latched rs operand (multiplicand / dividend)
//   rt_i     : latched rt operand (multiplier / divisor)
//   hi_res_o : HI result (product high word / remainder)
//   lo_res_o : LO result (product low word / quotient)
//   wr_en_o  : HI/LO write enable; low for divide by zero and non-arith ops
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_res_o,
  output logic [31:0] lo_res_o,
  output logic        wr_en_o
);

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] dvs_u;
  logic [31:0] q_u, r_u;
  logic [31:0] abs_a, abs_b, dvs_s;
  logic [31:0] q_mag, r_mag, q_s, r_s;

  // Sign-extending to 64 bits and keeping the low 64 bits of the product
  // gives the exact two's-complement signed product.
  assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  // Divisor forced to 1 on zero so the divider never sees x/0; the result
  // is discarded through wr_en_o anyway.
  assign div_zero = (rt_i == 32'd0);
  assign dvs_u    = div_zero ? 32'd1 : rt_i;
  assign q_u      = rs_i / dvs_u;
  assign r_u      = rs_i % dvs_u;

  // Signed divide on magnitudes. 0x80000000 has magnitude 2^31 as an
  // unsigned value, so 0x80000000 / -1 naturally yields lo=0x80000000, hi=0
  // without relying on a signed-overflow corner of the divider.
  assign abs_a = rs_i[31] ? (~rs_i + 32'd1) : rs_i;
  assign abs_b = rt_i[31] ? (~rt_i + 32'd1) : rt_i;
  assign dvs_s = div_zero ? 32'd1 : abs_b;
  assign q_mag = abs_a / dvs_s;
  assign r_mag = abs_a % dvs_s;
  assign q_s   = (rs_i[31] ^ rt_i[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = rs_i[31] ? (~r_mag + 32'd1) : r_mag;   // remainder follows dividend

  always_comb begin
    hi_res_o = 32'd0;
    lo_res_o = 32'd0;
    wr_en_o  = 1'b0;
    case (op_i)
      MD_MULT: begin
        {hi_res_o, lo_res_o} = prod_s;
        wr_en_o = 1'b1;
      end
      MD_MULTU: begin
        {hi_res_o, lo_res_o} = prod_u;
        wr_en_o = 1'b1;
      end
      MD_DIV: begin
        hi_res_o = r_s;
        lo_res_o = q_s;
        wr_en_o  = ~div_zero;
      end
      MD_DIVU: begin
        hi_res_o = r_u;
        lo_res_o = q_u;
        wr_en_o  = ~div_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer beside the EX-stage ALU.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : md_sequencer_if.slave
//           in : start, md_op, rs_val, rt_val
//           out: busy (registered), busy_real (comb), done (1-cycle pulse), hi, lo
// mult/multu/div/divu latch operands and hold busy for a fixed latency, then
// write HI/LO and pulse done. mthi/mtlo write directly from IDLE without busy.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q,    op_d;
  logic [31:0]      rs_q,    rs_d;
  logic [31:0]      rt_q,    rt_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;
  logic             done_q,  done_d;

  logic [31:0]      hi_res, lo_res;
  logic             res_wr;

  md_arith u_arith (
    .op_i     (op_q),
    .rs_i     (rs_q),
    .rt_i     (rt_q),
    .hi_res_o (hi_res),
    .lo_res_o (lo_res),
    .wr_en_o  (res_wr)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            MD_MULT, MD_MULTU: begin
              op_d    = bus.md_op;
              rs_d    = bus.rs_val;
              rt_d    = bus.rt_val;
              count_d = CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = bus.md_op;
              rs_d    = bus.rs_val;
              rt_d    = bus.rt_val;
              count_d = CNT_W'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            MD_MTHI: hi_d = bus.rs_val;
            MD_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Any start seen here is a hazard-unit violation and is dropped.
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          if (res_wr) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  // Unregistered so ID stalls in the very cycle a mult/div is launched.
  assign bus.busy_real = bus.busy | (bus.start & is_muldiv(bus.md_op));
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_sequencer_if bus();

  md_sequencer #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the next negedge (edge E0 between).
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    chk({tag, ":idle_before_start"}, 64'(bus.busy), 64'd0);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    chk({tag, ":busy_real"}, 64'(bus.busy_real), 64'((op >= 3'd1) && (op <= 3'd4)));
    @(negedge clk);
  endtask

  task automatic idle();
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  // Count busy cycles (bounded), then check done and pop the scoreboard.
  task automatic wait_done(input int n, input string tag);
    int   cyc = 0;
    exp_t e;
    while (bus.busy === 1'b1 && cyc < 40) begin
      if (cyc == 0) chk({tag, ":done_low_in_run"}, 64'(bus.done), 64'd0);
      cyc++;
      @(negedge clk);
      bus.rs_val = $urandom;   // operands must be ignored during RUN
      bus.rt_val = $urandom;
    end
    chk({tag, ":busy_cycles"}, 64'(cyc), 64'(n));
    chk({tag, ":done"}, 64'(bus.done), 64'd1);
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s: scoreboard observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ":hi"}, 64'(bus.hi), 64'(e.hi));
      chk({tag, ":lo"}, 64'(bus.lo), 64'(e.lo));
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo,
                        input string tag);
    sb.push_back({ehi, elo});
    drive(op, a, b, tag);
    idle();
    wait_done(n, tag);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    chk({tag, ":done_one_cycle"}, 64'(bus.done), 64'd0);
    chk({tag, ":busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst:busy", 64'(bus.busy), 64'd0);
    chk("rst:done", 64'(bus.done), 64'd0);
    chk("rst:hi", 64'(bus.hi), 64'd0);
    chk("rst:lo", 64'(bus.lo), 64'd0);
    chk("rst:busy_real_idle", 64'(bus.busy_real), 64'd0);
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    #1;
    chk("rst:busy_real_comb", 64'(bus.busy_real), 64'd1);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Arithmetic
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    pulse_end("mult");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
    pulse_end("multu");
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    pulse_end("div");

    // Divide by zero leaves preloaded HI/LO
    drive(MD_MTHI, 32'h11, 32'd0, "mthi11");
    idle();
    chk("mthi11:hi", 64'(bus.hi), 64'h11);
    drive(MD_MTLO, 32'h22, 32'd0, "mtlo22");
    idle();
    chk("mtlo22:lo", 64'(bus.lo), 64'h22);
    chk("mtlo22:hi", 64'(bus.hi), 64'h11);
    run_op(MD_DIVU, 32'd7, 32'd0, ND, 32'h11, 32'h22, "divu0");
    pulse_end("divu0");

    // Signed overflow
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000, "div_ovf");
    pulse_end("div_ovf");

    // mthi then mtlo on consecutive cycles
    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi");
    chk("mthi:hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mthi:lo_kept", 64'(bus.lo), 64'h8000_0000);
    drive(MD_MTLO, 32'h1234_5678, 32'd0, "mtlo");
    idle();
    chk("mtlo:lo", 64'(bus.lo), 64'h1234_5678);
    chk("mtlo:hi_kept", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mtlo:busy", 64'(bus.busy), 64'd0);
    chk("mtlo:done", 64'(bus.done), 64'd0);

    // No-op encodings and unqualified md_op
    drive(MD_RSVD, 32'd1, 32'd2, "rsvd");
    drive(MD_NONE, 32'd3, 32'd4, "none");
    bus.start = 1'b0;
    bus.md_op = MD_MULT;
    #1;
    chk("nostart:busy_real", 64'(bus.busy_real), 64'd0);
    @(negedge clk);
    idle();
    chk("noop:busy", 64'(bus.busy), 64'd0);
    chk("noop:hilo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_1234_5678);

    // Abort mid-RUN with reset
    drive(MD_MULT, 32'd5, 32'd6, "abort");
    idle();
    chk("abort:busy_c1", 64'(bus.busy), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort:busy", 64'(bus.busy), 64'd0);
    chk("abort:hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort:done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    chk("abort:no_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run_op(MD_DIV, 32'd9, 32'd4, ND, 32'd1, 32'd2, "div9_4");
    pulse_end("div9_4");

    // Back-to-back: div launched in the done cycle of a mult
    run_op(MD_MULT, 32'd3, 32'd4, NM, 32'd0, 32'd12, "b2b_mult");
    run_op(MD_DIV, 32'd100, 32'd7, ND, 32'd2, 32'd14, "b2b_div");
    pulse_end("b2b_div");

    chk("sb:drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
